// File: rtl/rat_ckpt_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : rat_ckpt_if
//  Brief    : Rename / commit / checkpoint bundle between the rename stage
//             (master) and the register alias table with checkpoints (slave).
//  Revision : 1.0 - initial release
// ============================================================================
interface rat_ckpt_if #(
   parameter int MACHINE_WIDTH = 2,
   parameter int TABLE_LEN     = 70,
   parameter int PW            = 7
);
   localparam int c_AW = $clog2(TABLE_LEN);

   // rename group
   logic [MACHINE_WIDTH-1:0]          ren_valid;
   logic [MACHINE_WIDTH*c_AW-1:0]     ren_src1;
   logic [MACHINE_WIDTH*c_AW-1:0]     ren_src2;
   logic [MACHINE_WIDTH*c_AW-1:0]     ren_dst;
   logic [MACHINE_WIDTH-1:0]          ren_dst_we;
   logic [MACHINE_WIDTH*PW-1:0]       ren_newp;
   logic [MACHINE_WIDTH*(1+PW)-1:0]   src1_p;
   logic [MACHINE_WIDTH*(1+PW)-1:0]   src2_p;
   logic [MACHINE_WIDTH*PW-1:0]       old_p;

   // checkpoint control
   logic                              ckpt_req;
   logic                              ckpt_full;
   logic                              ckpt_release;
   logic                              recover;

   // commit group
   logic [MACHINE_WIDTH-1:0]          com_valid;
   logic [MACHINE_WIDTH*c_AW-1:0]     com_dst;
   logic [MACHINE_WIDTH*PW-1:0]       com_p;
   logic                              flush;

   modport master (
      output ren_valid, ren_src1, ren_src2, ren_dst, ren_dst_we, ren_newp,
      output ckpt_req, ckpt_release, recover,
      output com_valid, com_dst, com_p, flush,
      input  src1_p, src2_p, old_p, ckpt_full
   );

   modport slave (
      input  ren_valid, ren_src1, ren_src2, ren_dst, ren_dst_we, ren_newp,
      input  ckpt_req, ckpt_release, recover,
      input  com_valid, com_dst, com_p, flush,
      output src1_p, src2_p, old_p, ckpt_full
   );
endinterface
`default_nettype wire

// File: rtl/rat_ckpt.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : rat_ckpt
//  Brief    : Register alias table with a speculative table (SRAT), a
//             committed table (CRAT) and a circular FIFO of SRAT snapshots
//             used to recover from branch mispredictions.
//  Revision : 1.0 - initial release
// ============================================================================
module rat_ckpt #(
   parameter int MACHINE_WIDTH = 2,
   parameter int TABLE_LEN     = 70,
   parameter int PW            = 7,
   parameter int CKPT_DEPTH    = 4
) (
   input  wire logic  clk,
   input  wire logic  resetn,
   rat_ckpt_if.slave  bus
);
   localparam int c_AW   = $clog2(TABLE_LEN);
   localparam int c_PTRW = (CKPT_DEPTH > 1) ? $clog2(CKPT_DEPTH) : 1;
   localparam int c_CNTW = $clog2(CKPT_DEPTH) + 1;
   localparam logic [c_AW:0]       c_TLEN = (c_AW+1)'(TABLE_LEN);
   localparam logic [c_CNTW-1:0]   c_FULL = c_CNTW'(CKPT_DEPTH);

   // one table entry: {valid, physical id}
   typedef logic [PW:0] ent_t;

   ent_t               r_srat [TABLE_LEN];
   ent_t               r_crat [TABLE_LEN];
   ent_t               r_ckpt [CKPT_DEPTH][TABLE_LEN];
   logic [c_PTRW-1:0]  r_head;
   logic [c_PTRW-1:0]  r_tail;
   logic [c_CNTW-1:0]  r_count;

   ent_t               w_srat_nxt [TABLE_LEN];
   ent_t               w_crat_nxt [TABLE_LEN];
   logic [MACHINE_WIDTH*(1+PW)-1:0] w_src1_pk;
   logic [MACHINE_WIDTH*(1+PW)-1:0] w_src2_pk;
   logic [MACHINE_WIDTH*PW-1:0]     w_old_pk;

   logic w_full;
   logic w_spec;
   logic w_use_crat;
   logic w_ckpt_load;
   logic w_rel;
   logic w_push;

   // Entry 0 is the hardwired zero register and addresses past the table
   // end do not exist, so neither may ever be written.
   function automatic logic f_wr_ok(input logic [c_AW-1:0] a);
      return (a != '0) && ({1'b0, a} < c_TLEN);
   endfunction

   // Control decode: flush beats recover, recover beats normal renaming.
   // A recover with nothing checkpointed falls back to the committed table.
   always_comb begin
      w_full      = (r_count == c_FULL);
      w_spec      = !bus.flush && !bus.recover;
      w_use_crat  = bus.flush || (bus.recover && (r_count == '0));
      w_ckpt_load = !bus.flush && bus.recover && (r_count != '0);
      w_rel       = w_spec && bus.ckpt_release && (r_count != '0);
      // a release in the same cycle frees the slot the new snapshot needs
      w_push      = w_spec && bus.ckpt_req && (!w_full || w_rel);
   end

   // Source and old-destination lookups with in-group bypass from older slots.
   always_comb begin
      logic [c_AW-1:0] w_a1;
      logic [c_AW-1:0] w_a2;
      logic [c_AW-1:0] w_ad;
      ent_t            w_e1;
      ent_t            w_e2;
      ent_t            w_eo;
      w_a1      = '0;
      w_a2      = '0;
      w_ad      = '0;
      w_e1      = '0;
      w_e2      = '0;
      w_eo      = '0;
      w_src1_pk = '0;
      w_src2_pk = '0;
      w_old_pk  = '0;
      for (int i = 0; i < MACHINE_WIDTH; i++) begin
         w_a1 = bus.ren_src1[i*c_AW +: c_AW];
         w_a2 = bus.ren_src2[i*c_AW +: c_AW];
         w_ad = bus.ren_dst[i*c_AW +: c_AW];
         w_e1 = ({1'b0, w_a1} < c_TLEN) ? r_srat[w_a1] : ent_t'(0);
         w_e2 = ({1'b0, w_a2} < c_TLEN) ? r_srat[w_a2] : ent_t'(0);
         w_eo = ({1'b0, w_ad} < c_TLEN) ? r_srat[w_ad] : ent_t'(0);
         // ascending scan so the youngest older writer is the last override
         for (int j = 0; j < i; j++) begin
            if (bus.ren_valid[j] && bus.ren_dst_we[j]) begin
               if (bus.ren_dst[j*c_AW +: c_AW] == w_a1)
                  w_e1 = {1'b1, bus.ren_newp[j*PW +: PW]};
               if (bus.ren_dst[j*c_AW +: c_AW] == w_a2)
                  w_e2 = {1'b1, bus.ren_newp[j*PW +: PW]};
               if (bus.ren_dst[j*c_AW +: c_AW] == w_ad)
                  w_eo = {1'b1, bus.ren_newp[j*PW +: PW]};
            end
         end
         if (w_a1 == '0) w_e1 = {1'b1, {PW{1'b0}}};
         if (w_a2 == '0) w_e2 = {1'b1, {PW{1'b0}}};
         if (w_ad == '0) w_eo = '0;
         w_src1_pk[i*(1+PW) +: 1+PW] = w_e1;
         w_src2_pk[i*(1+PW) +: 1+PW] = w_e2;
         w_old_pk[i*PW +: PW]        = w_eo[PW-1:0];
      end
   end

   assign bus.src1_p    = w_src1_pk;
   assign bus.src2_p    = w_src2_pk;
   assign bus.old_p     = w_old_pk;
   assign bus.ckpt_full = w_full;

   // Post-rename SRAT image; later slots overwrite earlier ones on collision.
   always_comb begin
      w_srat_nxt = r_srat;
      for (int i = 0; i < MACHINE_WIDTH; i++) begin
         if (bus.ren_valid[i] && bus.ren_dst_we[i] &&
             f_wr_ok(bus.ren_dst[i*c_AW +: c_AW]))
            w_srat_nxt[bus.ren_dst[i*c_AW +: c_AW]] = {1'b1, bus.ren_newp[i*PW +: PW]};
      end
   end

   // Post-commit CRAT image; later slots overwrite earlier ones on collision.
   always_comb begin
      w_crat_nxt = r_crat;
      for (int i = 0; i < MACHINE_WIDTH; i++) begin
         if (bus.com_valid[i] && f_wr_ok(bus.com_dst[i*c_AW +: c_AW]))
            w_crat_nxt[bus.com_dst[i*c_AW +: c_AW]] = {1'b1, bus.com_p[i*PW +: PW]};
      end
   end

   // Speculative table: identity on reset, then restore or rename.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int r = 0; r < TABLE_LEN; r++)
            r_srat[r] <= {1'b1, PW'(r)};
      end else if (w_use_crat) begin
         r_srat <= w_crat_nxt;
      end else if (w_ckpt_load) begin
         r_srat <= r_ckpt[r_head];
      end else begin
         r_srat <= w_srat_nxt;
      end
   end

   // Committed table: written every cycle, independent of flush/recover.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int r = 0; r < TABLE_LEN; r++)
            r_crat[r] <= {1'b1, PW'(r)};
      end else begin
         r_crat <= w_crat_nxt;
      end
   end

   // Snapshot FIFO pointers; any restore empties the FIFO.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else if (!w_spec) begin
         r_head  <= r_tail;
         r_count <= '0;
      end else begin
         if (w_push) r_tail <= r_tail + 1'b1;
         if (w_rel)  r_head <= r_head + 1'b1;
         r_count <= r_count + c_CNTW'(w_push) - c_CNTW'(w_rel);
      end
   end

   // Snapshot storage holds no reset value; only pushed slots are ever read.
   always_ff @(posedge clk) begin
      if (w_push)
         r_ckpt[r_tail] <= w_srat_nxt;
   end
endmodule
`default_nettype wire
